// File: rtl/instr_realigner.sv
// Fetch-path instruction realigner: splits a fetch block into 16/32-bit RISC-V
// instructions and carries the lower half of a block-straddling 32-bit
// instruction over to the next fetch.
module instr_realigner #(
  parameter int unsigned FETCH_WIDTH     = 32,
  parameter int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16,
  parameter int unsigned VLEN            = 64
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_i,
  input  logic                                       valid_i,
  output logic                                       serving_unaligned_o,
  input  logic [VLEN-1:0]                            address_i,
  input  logic [FETCH_WIDTH-1:0]                     data_i,
  output logic [INSTR_PER_FETCH-1:0]                 valid_o,
  output logic [INSTR_PER_FETCH-1:0][VLEN-1:0]       addr_o,
  output logic [INSTR_PER_FETCH-1:0][31:0]           instr_o
);

  // Halfword offset of address_i inside the fetch block.
  localparam int unsigned OFF_HI = $clog2(FETCH_WIDTH / 8) - 1;
  localparam int unsigned CNT_W  = $clog2(INSTR_PER_FETCH) + 1;

  logic            unaligned_q, unaligned_d;
  logic [15:0]     saved_instr_q, saved_instr_d;
  logic [VLEN-1:0] saved_addr_q, saved_addr_d;

  logic [CNT_W-1:0] avail;
  logic             upper_half;
  logic [15:0]      hw;

  assign serving_unaligned_o = unaligned_q;
  assign avail = CNT_W'(INSTR_PER_FETCH) - CNT_W'(address_i[OFF_HI:1]);

  // Parse halfwords left to right, emitting one instruction per start slot.
  always_comb begin
    unaligned_d   = 1'b0;
    saved_instr_d = saved_instr_q;
    saved_addr_d  = saved_addr_q;
    upper_half    = 1'b0;
    hw            = 16'h0;
    for (int k = 0; k < int'(INSTR_PER_FETCH); k++) begin
      valid_o[k] = 1'b0;
      instr_o[k] = 32'h0;
      addr_o[k]  = address_i + VLEN'(2 * k);
    end
    for (int k = 0; k < int'(INSTR_PER_FETCH); k++) begin
      hw = data_i[16*k +: 16];
      if (CNT_W'(k) < avail) begin
        if (k == 0 && unaligned_q) begin
          valid_o[0] = 1'b1;
          instr_o[0] = {hw, saved_instr_q};
          addr_o[0]  = saved_addr_q;
        end else if (upper_half) begin
          upper_half = 1'b0;
        end else if (hw[1:0] != 2'b11) begin
          valid_o[k] = 1'b1;
          instr_o[k] = {16'h0, hw};
        end else if (CNT_W'(k + 1) < avail) begin
          valid_o[k] = 1'b1;
          instr_o[k] = {data_i[16*(k+1) +: 16], hw};
          upper_half = 1'b1;
        end else begin
          unaligned_d   = 1'b1;
          saved_instr_d = hw;
          saved_addr_d  = address_i + VLEN'(2 * k);
        end
      end
    end
    valid_o = valid_o & {INSTR_PER_FETCH{valid_i}};
  end

  // Carried-halfword state; flush drops it, idle cycles hold it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      unaligned_q   <= 1'b0;
      saved_instr_q <= 16'h0;
      saved_addr_q  <= '0;
    end else if (flush_i) begin
      unaligned_q <= 1'b0;
    end else if (valid_i) begin
      unaligned_q <= unaligned_d;
      if (unaligned_d) begin
        saved_instr_q <= saved_instr_d;
        saved_addr_q  <= saved_addr_d;
      end
    end
  end

endmodule

// File: tb/tb_instr_realigner.sv
// Directed bench for instr_realigner with FETCH_WIDTH=32.
module tb_instr_realigner;

  localparam int unsigned FW   = 32;
  localparam int unsigned NI   = FW / 16;
  localparam int unsigned VLEN = 64;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      flush_i = 1'b0;
  logic                      valid_i = 1'b0;
  logic                      serving_unaligned_o;
  logic [VLEN-1:0]           address_i = '0;
  logic [FW-1:0]             data_i = '0;
  logic [NI-1:0]             valid_o;
  logic [NI-1:0][VLEN-1:0]   addr_o;
  logic [NI-1:0][31:0]       instr_o;

  int checks = 0;
  int errors = 0;

  instr_realigner #(.FETCH_WIDTH(FW), .INSTR_PER_FETCH(NI), .VLEN(VLEN)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .serving_unaligned_o (serving_unaligned_o),
    .address_i           (address_i),
    .data_i              (data_i),
    .valid_o             (valid_o),
    .addr_o              (addr_o),
    .instr_o             (instr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, leave time to settle.
  task automatic apply(input logic v, input logic fl, input logic [63:0] a, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    valid_i   = v;
    flush_i   = fl;
    address_i = a;
    data_i    = d;
    #3;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  initial begin
    #3;
    check("rst_serving", 64'(serving_unaligned_o), 64'h0);
    check("rst_valid", 64'(valid_o), 64'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Two compressed zeros
    apply(1'b1, 1'b0, 64'h0, 32'h0000_0000);
    check("t1_valid", 64'(valid_o), 64'h3);
    check("t1_instr0", 64'(instr_o[0]), 64'h0);
    check("t1_instr1", 64'(instr_o[1]), 64'h0);
    check("t1_addr0", addr_o[0], 64'h0);
    check("t1_addr1", addr_o[1], 64'h2);
    check("t1_serving", 64'(serving_unaligned_o), 64'h0);

    // One aligned 32-bit instruction
    apply(1'b1, 1'b0, 64'h0, 32'h0000_0013);
    check("t2_valid", 64'(valid_o), 64'h1);
    check("t2_instr0", 64'(instr_o[0]), 64'h13);
    check("t2_instr1", 64'(instr_o[1]), 64'h0);
    idle();
    check("t2_serving", 64'(serving_unaligned_o), 64'h0);
    check("idle_valid", 64'(valid_o), 64'h0);

    // Straddle then completion
    apply(1'b1, 1'b0, 64'h100, 32'h0013_4001);
    check("s1_valid", 64'(valid_o), 64'h1);
    check("s1_instr0", 64'(instr_o[0]), 64'h4001);
    check("s1_addr0", addr_o[0], 64'h100);
    apply(1'b1, 1'b0, 64'h104, 32'h4001_0000);
    check("s2_serving", 64'(serving_unaligned_o), 64'h1);
    check("s2_valid", 64'(valid_o), 64'h3);
    check("s2_instr0", 64'(instr_o[0]), 64'h13);
    check("s2_addr0", addr_o[0], 64'h102);
    check("s2_instr1", 64'(instr_o[1]), 64'h4001);
    check("s2_addr1", addr_o[1], 64'h106);
    idle();
    check("s3_serving", 64'(serving_unaligned_o), 64'h0);

    // Straddle then flush with valid_i low
    apply(1'b1, 1'b0, 64'h100, 32'h0013_4001);
    idle();
    check("f0_serving", 64'(serving_unaligned_o), 64'h1);
    apply(1'b0, 1'b1, 64'h0, 32'h0);
    idle();
    check("f1_serving", 64'(serving_unaligned_o), 64'h0);
    apply(1'b1, 1'b0, 64'h200, 32'h0000_0013);
    check("f2_valid", 64'(valid_o), 64'h1);
    check("f2_instr0", 64'(instr_o[0]), 64'h13);
    check("f2_addr0", addr_o[0], 64'h200);

    // Flush together with the completing fetch: outputs still driven
    apply(1'b1, 1'b0, 64'h100, 32'h0013_4001);
    apply(1'b1, 1'b1, 64'h104, 32'h0000_0000);
    check("fv_valid", 64'(valid_o), 64'h3);
    check("fv_instr0", 64'(instr_o[0]), 64'h13);
    idle();
    check("fv_serving", 64'(serving_unaligned_o), 64'h0);

    // Odd halfword offset: one slot available
    apply(1'b1, 1'b0, 64'h102, 32'h0000_0001);
    check("o1_valid", 64'(valid_o), 64'h1);
    check("o1_instr0", 64'(instr_o[0]), 64'h1);
    check("o1_addr0", addr_o[0], 64'h102);
    apply(1'b1, 1'b0, 64'h102, 32'h0000_0003);
    check("o2_valid", 64'(valid_o), 64'h0);
    idle();
    check("o2_serving", 64'(serving_unaligned_o), 64'h1);
    apply(1'b1, 1'b0, 64'h104, 32'h0000_0013);
    check("o3_valid", 64'(valid_o), 64'h3);
    check("o3_instr0", 64'(instr_o[0]), 64'h0013_0003);
    check("o3_addr0", addr_o[0], 64'h102);
    check("o3_instr1", 64'(instr_o[1]), 64'h0);
    check("o3_addr1", addr_o[1], 64'h106);

    // Address wrap-around across the straddle
    apply(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0003);
    check("w1_valid", 64'(valid_o), 64'h0);
    apply(1'b1, 1'b0, 64'h0, 32'h0000_0013);
    check("w2_valid", 64'(valid_o), 64'h3);
    check("w2_instr0", 64'(instr_o[0]), 64'h0013_0003);
    check("w2_addr0", addr_o[0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("w2_addr1", addr_o[1], 64'h2);

    // Asynchronous reset mid-straddle
    apply(1'b1, 1'b0, 64'h102, 32'h0000_0003);
    idle();
    check("r0_serving", 64'(serving_unaligned_o), 64'h1);
    #1 rst_i = 1'b1;
    #1;
    check("r1_serving", 64'(serving_unaligned_o), 64'h0);
    check("r1_valid", 64'(valid_o), 64'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    apply(1'b1, 1'b0, 64'h104, 32'h4001_0000);
    check("r2_valid", 64'(valid_o), 64'h3);
    check("r2_instr0", 64'(instr_o[0]), 64'h0);
    check("r2_addr0", addr_o[0], 64'h104);
    check("r2_instr1", 64'(instr_o[1]), 64'h4001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
